sb_drain_unit: RTL and testbench

//  Downstream of the store buffer: pops committed store entries one at a time
//  and writes each to the data-memory write port (req/ack + response).

---
 rtl/sb_drain_unit_pkg.sv | 31 +++
 rtl/sb_drain_unit.sv | 145 ++++++++++++++
 tb/tb_sb_drain_unit.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sb_drain_unit_pkg.sv
// ----------------------------------------------------------------------------
// sb_drain_unit_pkg
//   Shared types for the store-buffer drain path.
//   sb_entry_t        : one committed store as popped from the store buffer
//   sb_drain_state_e  : drain FSM state encoding
//   word_align()      : clears the byte-offset bits of a store address
// ----------------------------------------------------------------------------
package sb_drain_unit_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  wstrb;
        logic        valid;
        logic        commit;
    } sb_entry_t;

    typedef enum logic [1:0] {
        SB_DRAIN_IDLE = 2'd0,
        SB_DRAIN_REQ  = 2'd1,
        SB_DRAIN_WAIT = 2'd2
    } sb_drain_state_e;

    localparam int SB_DRAIN_MAX_RETRY_DEF = 2;
    localparam int SB_DRAIN_CNT_W_DEF     = 32;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/sb_drain_unit.sv
// ----------------------------------------------------------------------------
// sb_drain_unit
//   Pops committed stores from the store buffer one at a time and writes each
//   to the data-memory write port. The single in-flight store is held in a
//   pend register, reissued on error responses (up to MAX_RETRY times) and
//   exposed to the LSU for address-conflict checks.
//
// Ports
//   clk, rst                 single clock, synchronous active-high reset
//   sb_entry_valid/ready/data  receiver side of the store-buffer handshake
//   mem_req_valid/ready      write request handshake
//   mem_req_addr/data/strb   word-aligned address, write data, byte strobes
//   mem_resp_valid/err       write response and its error flag
//   pend_valid_o/entry_o     held store (valid whenever not IDLE)
//   drain_idle_o             FSM is IDLE
//   err_o                    sticky: a store was dropped after MAX_RETRY
//   drained_cnt_o            count of completed stores (wraps)
// ----------------------------------------------------------------------------
module sb_drain_unit
    import sb_drain_unit_pkg::*;
#(
    parameter int MAX_RETRY = SB_DRAIN_MAX_RETRY_DEF,
    parameter int CNT_W     = SB_DRAIN_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    // store-buffer receiver
    input  logic             sb_entry_valid,
    output logic             sb_entry_ready,
    input  sb_entry_t        sb_entry_data,
    // memory write port
    output logic             mem_req_valid,
    input  logic             mem_req_ready,
    output logic [31:0]      mem_req_addr,
    output logic [31:0]      mem_req_data,
    output logic [3:0]       mem_req_strb,
    input  logic             mem_resp_valid,
    input  logic             mem_resp_err,
    // status
    output logic             pend_valid_o,
    output sb_entry_t        pend_entry_o,
    output logic             drain_idle_o,
    output logic             err_o,
    output logic [CNT_W-1:0] drained_cnt_o
);

    localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);

    sb_drain_state_e    state_q, state_d;
    sb_entry_t          pend_q, pend_d;
    logic [RETRY_W-1:0] retry_cnt_q, retry_cnt_d;
    logic [CNT_W-1:0]   drained_cnt_q, drained_cnt_d;
    logic               err_q, err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= SB_DRAIN_IDLE;
            pend_q        <= '0;
            retry_cnt_q   <= '0;
            drained_cnt_q <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            pend_q        <= pend_d;
            retry_cnt_q   <= retry_cnt_d;
            drained_cnt_q <= drained_cnt_d;
            err_q         <= err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pend_d        = pend_q;
        retry_cnt_d   = retry_cnt_q;
        drained_cnt_d = drained_cnt_q;
        err_d         = err_q;

        case (state_q)
            SB_DRAIN_IDLE: begin
                // ready is 1 in IDLE, so valid alone completes the handshake
                if (sb_entry_valid) begin
                    if (sb_entry_data.wstrb == 4'b0000) begin
                        // nothing to write: retire without touching memory
                        drained_cnt_d = drained_cnt_q + CNT_W'(1);
                    end else begin
                        pend_d      = sb_entry_data;
                        retry_cnt_d = '0;
                        state_d     = SB_DRAIN_REQ;
                    end
                end
            end
            SB_DRAIN_REQ: begin
                if (mem_req_ready) begin
                    state_d = SB_DRAIN_WAIT;
                end
            end
            SB_DRAIN_WAIT: begin
                // responses are only honoured here; one arriving in the
                // ack cycle is a protocol violation and is ignored
                if (mem_resp_valid) begin
                    if (!mem_resp_err) begin
                        drained_cnt_d = drained_cnt_q + CNT_W'(1);
                        pend_d        = '0;
                        state_d       = SB_DRAIN_IDLE;
                    end else if (retry_cnt_q < RETRY_LIMIT) begin
                        retry_cnt_d = retry_cnt_q + RETRY_W'(1);
                        state_d     = SB_DRAIN_REQ;
                    end else begin
                        // retries exhausted: drop the store, flag it
                        err_d   = 1'b1;
                        pend_d  = '0;
                        state_d = SB_DRAIN_IDLE;
                    end
                end
            end
            default: begin
                pend_d  = '0;
                state_d = SB_DRAIN_IDLE;
            end
        endcase
    end

    // All handshake outputs depend only on registered state, so there is no
    // combinational path from the memory port back to the store buffer.
    always_comb begin
        sb_entry_ready = (state_q == SB_DRAIN_IDLE);
        mem_req_valid  = (state_q == SB_DRAIN_REQ);
        mem_req_addr   = '0;
        mem_req_data   = '0;
        mem_req_strb   = '0;
        if (state_q == SB_DRAIN_REQ) begin
            mem_req_addr = word_align(pend_q.addr);
            mem_req_data = pend_q.data;
            mem_req_strb = pend_q.wstrb;
        end
    end

    assign pend_valid_o  = (state_q != SB_DRAIN_IDLE);
    assign pend_entry_o  = pend_q;
    assign drain_idle_o  = (state_q == SB_DRAIN_IDLE);
    assign err_o         = err_q;
    assign drained_cnt_o = drained_cnt_q;

endmodule

// File: tb/tb_sb_drain_unit.sv
// ----------------------------------------------------------------------------
// tb_sb_drain_unit
//   Self-checking bench for sb_drain_unit: a table of directed stores, a few
//   hand-written reset/retry sequences, then randomized stores checked
//   against a transaction-level model (expected completions and sticky error
//   derived from the number of error responses each store receives).
// ----------------------------------------------------------------------------
module tb_sb_drain_unit;
    import sb_drain_unit_pkg::*;

    localparam int MAX_RETRY = 2;
    localparam int CNT_W     = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             sb_entry_valid;
    logic             sb_entry_ready;
    sb_entry_t        sb_entry_data;
    logic             mem_req_valid;
    logic             mem_req_ready;
    logic [31:0]      mem_req_addr;
    logic [31:0]      mem_req_data;
    logic [3:0]       mem_req_strb;
    logic             mem_resp_valid;
    logic             mem_resp_err;
    logic             pend_valid_o;
    sb_entry_t        pend_entry_o;
    logic             drain_idle_o;
    logic             err_o;
    logic [CNT_W-1:0] drained_cnt_o;

    sb_drain_unit #(.MAX_RETRY(MAX_RETRY), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .sb_entry_valid (sb_entry_valid),
        .sb_entry_ready (sb_entry_ready),
        .sb_entry_data  (sb_entry_data),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_req_data   (mem_req_data),
        .mem_req_strb   (mem_req_strb),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_err   (mem_resp_err),
        .pend_valid_o   (pend_valid_o),
        .pend_entry_o   (pend_entry_o),
        .drain_idle_o   (drain_idle_o),
        .err_o          (err_o),
        .drained_cnt_o  (drained_cnt_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state: stores retired and sticky drop flag
    int   exp_cnt = 0;
    logic exp_err = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        exp_cnt = 0;
        exp_err = 1'b0;
    endtask

    // Drive one store through the unit. The memory side holds ready low for
    // 'stall' cycles per request and answers the first n_err requests with
    // an error. With hold_next set, a second entry is offered during the
    // stall to prove it is not popped.
    task automatic send_store(input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, input int n_err,
                              input int stall, input logic hold_next);
        sb_entry_t   e;
        logic [31:0] exp_addr;
        logic        is_err;
        int          gap;
        e        = '{addr: addr, data: data, wstrb: strb, valid: 1'b1, commit: 1'b1};
        exp_addr = addr & 32'hFFFF_FFFC;
        $display("store addr=0x%08h data=0x%08h strb=%b errs=%0d stall=%0d",
                 addr, data, strb, n_err, stall);
        check("ready_before_accept", 64'(sb_entry_ready), 64'd1);
        sb_entry_valid = 1'b1;
        sb_entry_data  = e;
        tick();
        sb_entry_valid = 1'b0;
        sb_entry_data  = '0;
        if (strb == 4'b0000) begin
            exp_cnt++;
            check("zero_strb_no_req", 64'(mem_req_valid), 64'd0);
            check("zero_strb_ready", 64'(sb_entry_ready), 64'd1);
        end else begin
            for (int a = 0; a <= MAX_RETRY; a++) begin
                check("req_valid", 64'(mem_req_valid), 64'd1);
                check("req_addr", 64'(mem_req_addr), 64'(exp_addr));
                check("req_data", 64'(mem_req_data), 64'(data));
                check("req_strb", 64'(mem_req_strb), 64'(strb));
                check("pend_valid", 64'(pend_valid_o), 64'd1);
                check("pend_addr", 64'(pend_entry_o.addr), 64'(addr));
                for (int s = 0; s < stall; s++) begin
                    if (hold_next) begin
                        sb_entry_valid = 1'b1;
                        sb_entry_data  = '{addr: 32'h0BAD_0000, data: 32'h0BAD_BEEF,
                                          wstrb: 4'hF, valid: 1'b1, commit: 1'b1};
                    end
                    tick();
                    check("stall_valid", 64'(mem_req_valid), 64'd1);
                    check("stall_addr", 64'(mem_req_addr), 64'(exp_addr));
                    check("stall_data", 64'(mem_req_data), 64'(data));
                    check("stall_rdy_low", 64'(sb_entry_ready), 64'd0);
                end
                sb_entry_valid = 1'b0;
                sb_entry_data  = '0;
                mem_req_ready  = 1'b1;
                tick();
                mem_req_ready = 1'b0;
                check("wait_no_req", 64'(mem_req_valid), 64'd0);
                gap = int'($urandom_range(0, 2));
                repeat (gap) tick();
                is_err         = (a < n_err);
                mem_resp_valid = 1'b1;
                mem_resp_err   = is_err;
                tick();
                mem_resp_valid = 1'b0;
                mem_resp_err   = 1'b0;
                if (!is_err) begin
                    exp_cnt++;
                    break;
                end
                if (a == MAX_RETRY) begin
                    exp_err = 1'b1;
                end
            end
        end
        check("idle_after_store", 64'(drain_idle_o), 64'd1);
        check("pend_cleared", 64'(pend_valid_o), 64'd0);
        check("drained_cnt", 64'(drained_cnt_o), 64'(exp_cnt));
        check("err_sticky", 64'(err_o), 64'(exp_err));
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          n_err;
        int          stall;
        int          exp_cnt_after;
        logic        exp_err_after;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'h8000_0013, 32'hDEAD_BEEF, 4'b1000, 0, 0, 1, 1'b0};
        vecs[1] = '{32'h0000_1004, 32'h1234_5678, 4'b1111, 0, 5, 2, 1'b0};
        vecs[2] = '{32'h0000_2002, 32'hAAAA_5555, 4'b0011, 1, 1, 3, 1'b0};
        vecs[3] = '{32'h0000_3000, 32'h0000_0000, 4'b0000, 0, 0, 4, 1'b0};
        vecs[4] = '{32'h0000_4001, 32'hCAFE_F00D, 4'b0110, 3, 0, 4, 1'b1};
        vecs[5] = '{32'h0000_5000, 32'h1111_2222, 4'b1111, 0, 2, 5, 1'b1};
        vecs[6] = '{32'hFFFF_FFFF, 32'h5A5A_A5A5, 4'b0001, 2, 1, 6, 1'b1};

        rst            = 1'b0;
        sb_entry_valid = 1'b0;
        sb_entry_data  = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_err   = 1'b0;

        // T1: reset state
        do_reset();
        check("rst_ready", 64'(sb_entry_ready), 64'd1);
        check("rst_req_valid", 64'(mem_req_valid), 64'd0);
        check("rst_req_addr", 64'(mem_req_addr), 64'd0);
        check("rst_err", 64'(err_o), 64'd0);
        check("rst_cnt", 64'(drained_cnt_o), 64'd0);
        check("rst_idle", 64'(drain_idle_o), 64'd1);
        check("rst_pend", 64'(pend_valid_o), 64'd0);

        // directed table (T2, T3, T5, retry then success, drop)
        foreach (vecs[i]) begin
            send_store(vecs[i].addr, vecs[i].data, vecs[i].strb,
                       vecs[i].n_err, vecs[i].stall, vecs[i].stall > 0);
            check("tbl_cnt", 64'(drained_cnt_o), 64'(vecs[i].exp_cnt_after));
            check("tbl_err", 64'(err_o), 64'(vecs[i].exp_err_after));
        end

        // T6: reset while waiting for the response, then a late response
        do_reset();
        sb_entry_valid = 1'b1;
        sb_entry_data  = '{addr: 32'h0000_6000, data: 32'h6666_6666,
                          wstrb: 4'hF, valid: 1'b1, commit: 1'b1};
        tick();
        sb_entry_valid = 1'b0;
        sb_entry_data  = '0;
        mem_req_ready  = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        check("t6_in_wait", 64'(drain_idle_o), 64'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_idle_after_rst", 64'(drain_idle_o), 64'd1);
        check("t6_req_dropped", 64'(mem_req_valid), 64'd0);
        mem_resp_valid = 1'b1;
        tick();
        mem_resp_valid = 1'b0;
        check("t6_late_resp_idle", 64'(drain_idle_o), 64'd1);
        check("t6_late_resp_cnt", 64'(drained_cnt_o), 64'd0);
        check("t6_ready", 64'(sb_entry_ready), 64'd1);
        $display("reset during WAIT, late response applied");

        // T4: from clean reset, three error responses drop the store
        send_store(32'h0000_7008, 32'h7777_0000, 4'b1100, 3, 0, 1'b0);
        check("t4_cnt_zero", 64'(drained_cnt_o), 64'd0);
        check("t4_err_set", 64'(err_o), 64'd1);
        send_store(32'h0000_700C, 32'h7777_1111, 4'b0011, 0, 0, 1'b0);
        check("t4_cnt_one", 64'(drained_cnt_o), 64'd1);
        check("t4_err_stays", 64'(err_o), 64'd1);

        // randomized stores against the model
        do_reset();
        for (int n = 0; n < 40; n++) begin
            logic [3:0] rs;
            rs = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
            send_store($urandom, $urandom, rs, int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
